alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu.sv | 81 ++++++++
 rtl/muldiv_iter.sv | 128 ++++++++++++
 rtl/alu_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU controller: MIPS opcode/funct codes,
// FSM state encoding, zon flag bit positions and multiply/divide operation codes.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MD_RUN, S_RESP} state_e;

  localparam int ZON_Z = 2;
  localparam int ZON_V = 1;
  localparam int ZON_N = 0;

  typedef enum logic [1:0] {MD_MUL, MD_MULU, MD_DIV, MD_DIVU} md_op_e;

endpackage

// File: rtl/alu.sv
// Combinational single-cycle MIPS ALU. Unrecognised encodings give c=0, which
// naturally yields zon=3'b100.
module alu import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] c,
  output logic [2:0]      zon
);

  localparam int MSB = XLEN - 1;

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [4:0]      shamt;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_z;
  logic            ovf;
  logic            unused_fields;

  assign op            = instr[31:26];
  assign fn            = instr[5:0];
  assign shamt         = instr[10:6];
  assign imm_s         = {{(XLEN-16){instr[15]}}, instr[15:0]};
  assign imm_z         = {{(XLEN-16){1'b0}}, instr[15:0]};
  assign unused_fields = ^instr[25:16];

  always_comb begin
    c   = '0;
    ovf = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_SLL:  c = b << shamt;
          F_SRL:  c = b >> shamt;
          F_SRA:  c = $signed(b) >>> shamt;
          F_SLLV: c = b << a[4:0];
          F_SRLV: c = b >> a[4:0];
          F_SRAV: c = $signed(b) >>> a[4:0];
          F_ADD: begin
            c   = a + b;
            ovf = (a[MSB] == b[MSB]) && (c[MSB] != a[MSB]);
          end
          F_ADDU: c = a + b;
          F_SUB: begin
            c   = a - b;
            ovf = (a[MSB] != b[MSB]) && (c[MSB] != a[MSB]);
          end
          F_SUBU: c = a - b;
          F_AND:  c = a & b;
          F_OR:   c = a | b;
          F_XOR:  c = a ^ b;
          F_NOR:  c = ~(a | b);
          F_SLT:  c = XLEN'($signed(a) < $signed(b));
          F_SLTU: c = XLEN'(a < b);
          default: c = '0;
        endcase
      end
      // Branches only need the zero flag of a - b.
      OP_BEQ, OP_BNE: c = a - b;
      OP_ADDI: begin
        c   = a + imm_s;
        ovf = (a[MSB] == imm_s[MSB]) && (c[MSB] != a[MSB]);
      end
      OP_ADDIU, OP_LW, OP_SW: c = a + imm_s;
      OP_SLTI:  c = XLEN'($signed(a) < $signed(imm_s));
      OP_SLTIU: c = XLEN'(a < imm_s);
      OP_ANDI:  c = a & imm_z;
      OP_ORI:   c = a | imm_z;
      OP_XORI:  c = a ^ imm_z;
      default:  c = '0;
    endcase
    zon        = '0;
    zon[ZON_Z] = (c == '0);
    zon[ZON_V] = ovf;
    zon[ZON_N] = c[MSB];
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative sign-magnitude shift-add multiplier and restoring divider, one bit
// per cycle. The divide path exists only when ALU_SEQ_CTRL_DIV_EN is defined.
module muldiv_iter import alu_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32   // must be >= XLEN; extra cycles hold the result
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            ovf
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  logic              running;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic              neg_q;

  logic              sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   mb;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] fin;
  logic [2*XLEN-1:0] prod;

  assign sgn   = (op == MD_MUL) || (op == MD_DIV);
  assign a_neg = sgn & a[XLEN-1];
  assign b_neg = sgn & b[XLEN-1];
  assign ma    = a_neg ? -a : a;
  assign mb    = b_neg ? -b : b;
  assign done  = running && (cnt == CW'(MD_CYCLES - 1));

`ifdef ALU_SEQ_CTRL_DIV_EN
  logic              is_div_q;
  logic              rneg_q;
  logic              dvz_q;
  logic              ovf_q;
  logic [XLEN-1:0]   dvd_q;
  logic [XLEN:0]     div_shl;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dvz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dvd_q    <= '0;
    end else if (start) begin
      is_div_q <= (op == MD_DIV) || (op == MD_DIVU);
      rneg_q   <= a_neg;
      dvz_q    <= (b == '0);
      ovf_q    <= (op == MD_DIV) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      dvd_q    <= a;
    end
  end

  // Restoring step: acc holds {remainder, dividend bits not yet consumed / quotient}.
  always_comb begin
    div_shl  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_shl - {1'b0, opb};
    if (!div_diff[XLEN]) div_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                 div_step = {div_shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end
`endif

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    step    = {mul_sum, acc[XLEN-1:1]};
`ifdef ALU_SEQ_CTRL_DIV_EN
    if (is_div_q) step = div_step;
`endif
    fin  = (int'(cnt) < XLEN) ? step : acc;
    prod = neg_q ? -fin : fin;
    hi   = prod[2*XLEN-1:XLEN];
    lo   = prod[XLEN-1:0];
    ovf  = 1'b0;
`ifdef ALU_SEQ_CTRL_DIV_EN
    quo = fin[XLEN-1:0];
    rem = fin[2*XLEN-1:XLEN];
    if (is_div_q) begin
      if (dvz_q) begin
        lo = '1;
        hi = dvd_q;
      end else begin
        lo = neg_q  ? -quo : quo;
        hi = rneg_q ? -rem : rem;
      end
      ovf = ovf_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      neg_q   <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= {{XLEN{1'b0}}, ma};
      opb     <= mb;
      neg_q   <= a_neg ^ b_neg;
    end else if (running) begin
      acc <= fin;
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller around the single-cycle ALU and the iterative
// multiply/divide unit. Divide is built only with ALU_SEQ_CTRL_DIV_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; out_valid/result/zon stay stable until that edge.
module alu_seq_ctrl import alu_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     i_datain,
  input  logic [XLEN-1:0] gr1,
  input  logic [XLEN-1:0] gr2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [2:0]      zon,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output state_e          dbg_state
);

  state_e          state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  logic [XLEN-1:0] alu_c;
  logic [2:0]      alu_zon;
  logic            is_rtype;
  logic            is_mfhi;
  logic            is_mflo;
  logic            md_go;
  md_op_e          md_sel;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_hi;
  logic [XLEN-1:0] md_lo;
  logic            md_ovf;

  function automatic logic [2:0] flags(input logic [XLEN-1:0] v, input logic v_ovf);
    logic [2:0] f;
    f        = '0;
    f[ZON_Z] = (v == '0);
    f[ZON_V] = v_ovf;
    f[ZON_N] = v[XLEN-1];
    return f;
  endfunction

  assign dbg_state = state;

  alu #(.XLEN(XLEN)) u_alu (
    .instr (instr_q),
    .a     (a_q),
    .b     (b_q),
    .c     (alu_c),
    .zon   (alu_zon)
  );

  always_comb begin
    is_rtype = (instr_q[31:26] == OP_RTYPE);
    is_mfhi  = is_rtype && (instr_q[5:0] == F_MFHI);
    is_mflo  = is_rtype && (instr_q[5:0] == F_MFLO);
    md_go    = 1'b0;
    md_sel   = MD_MUL;
    if (is_rtype) begin
      case (instr_q[5:0])
        F_MULT:  begin md_go = 1'b1; md_sel = MD_MUL;  end
        F_MULTU: begin md_go = 1'b1; md_sel = MD_MULU; end
`ifdef ALU_SEQ_CTRL_DIV_EN
        F_DIV:   begin md_go = 1'b1; md_sel = MD_DIV;  end
        F_DIVU:  begin md_go = 1'b1; md_sel = MD_DIVU; end
`endif
        default: md_go = 1'b0;
      endcase
    end
  end

  assign md_start = (state == S_EXEC) && md_go;

  muldiv_iter #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_sel),
    .a     (a_q),
    .b     (b_q),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo),
    .ovf   (md_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zon       <= '0;
      hi        <= '0;
      lo        <= '0;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            instr_q  <= i_datain;
            a_q      <= gr1;
            b_q      <= gr2;
            in_ready <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (md_go) begin
            busy  <= 1'b1;
            state <= S_MD_RUN;
          end else begin
            if (is_mfhi) begin
              result <= hi;
              zon    <= flags(hi, 1'b0);
            end else if (is_mflo) begin
              result <= lo;
              zon    <= flags(lo, 1'b0);
            end else begin
              result <= alu_c;
              zon    <= alu_zon;
            end
            out_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        // hi/lo commit together with the move to RESP so an abort leaves them intact.
        S_MD_RUN: begin
          if (md_done) begin
            hi        <= md_hi;
            lo        <= md_lo;
            result    <= '0;
            zon       <= flags(md_lo, md_ovf);
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed-vector bench for alu_seq_ctrl with a queue-based scoreboard; divide
// expectations follow ALU_SEQ_CTRL_DIV_EN.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i_datain;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  zon;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res_q[$];
  logic [2:0]  exp_zon_q[$];
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  string       exp_name_q[$];

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  alu_seq_ctrl #(.XLEN(32), .MD_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_datain  (i_datain),
    .gr1       (gr1),
    .gr2       (gr2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zon       (zon),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h with empty expected queue", result);
      end else begin
        string nm;
        nm = exp_name_q.pop_front();
        check({nm, "_result"}, result, exp_res_q.pop_front());
        check({nm, "_zon"}, 32'(zon), 32'(exp_zon_q.pop_front()));
        check({nm, "_hi"}, hi, exp_hi_q.pop_front());
        check({nm, "_lo"}, lo, exp_lo_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input string nm, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er, input logic [2:0] ez,
                      input logic [31:0] eh, input logic [31:0] el, input bit push);
    int n;
    if (push) begin
      exp_name_q.push_back(nm);
      exp_res_q.push_back(er);
      exp_zon_q.push_back(ez);
      exp_hi_q.push_back(eh);
      exp_lo_q.push_back(el);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    i_datain = ins;
    gr1      = a;
    gr2      = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready 0 expected 1 within 100 cycles", nm);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic run_op(input string nm, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [2:0] ez,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    send(nm, ins, a, b, er, ez, eh, el, 1'b1);
    wait_valid(lat, bcnt);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
    @(posedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int bcnt;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    i_datain  = '0;
    gr1       = '0;
    gr2       = '0;
    out_ready = 1'b1;
    m_hi      = '0;
    m_lo      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zon", 32'(zon), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // add, no overflow
    run_op("add", 32'h0000_0020, 32'h4040_4040, 32'hDDDD_DDDD, 32'h1E1E_1E1D, 3'b000, m_hi, m_lo, 2, 0);

    // sub with back-pressure: output must hold while out_ready is low
    @(posedge clk);
    #2 out_ready = 1'b0;
    send("sub_hold", 32'h0000_0022, 32'h5, 32'h7, 32'hFFFF_FFFE, 3'b001, m_hi, m_lo, 1'b1);
    wait_valid(lat, bcnt);
    check("sub_hold_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'hFFFF_FFFE);
      check("hold_zon", 32'(zon), 32'b001);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready_before", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release_out_valid_after", 32'(out_valid), 32'd0);
    check("release_in_ready_after", 32'(in_ready), 32'd1);

    // multiply / move-from
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFF;
    run_op("mult_m1x1", 32'h0000_0018, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b001, m_hi, m_lo, 34, 32);
    run_op("mfhi", 32'h0000_0010, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b001, m_hi, m_lo, 2, 0);
    m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;
    run_op("multu_max", 32'h0000_0019, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b000, m_hi, m_lo, 34, 32);
    run_op("mflo", 32'h0000_0012, 32'h0, 32'h0, 32'h0000_0001, 3'b000, m_hi, m_lo, 2, 0);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
    run_op("mult_7xm3", 32'h0000_0018, 32'h7, 32'hFFFF_FFFD, 32'h0, 3'b001, m_hi, m_lo, 34, 32);

`ifdef ALU_SEQ_CTRL_DIV_EN
    m_hi = 32'hFFFF_FFF2; m_lo = 32'hFFFF_FFFF;
    run_op("div_neg", 32'h0000_001A, 32'hFFFF_FFE1, 32'h11, 32'h0, 3'b001, m_hi, m_lo, 34, 32);
    m_hi = 32'h0000_000D; m_lo = 32'hFFFF_FFFF;
    run_op("divu_by0", 32'h0000_001B, 32'hD, 32'h0, 32'h0, 3'b001, m_hi, m_lo, 34, 32);
    m_hi = 32'h0; m_lo = 32'h8000_0000;
    run_op("div_ovf", 32'h0000_001A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 3'b011, m_hi, m_lo, 34, 32);
`else
    run_op("div_off", 32'h0000_001A, 32'hFFFF_FFE1, 32'h11, 32'h0, 3'b100, m_hi, m_lo, 2, 0);
    run_op("divu_off", 32'h0000_001B, 32'hD, 32'h0, 32'h0, 3'b100, m_hi, m_lo, 2, 0);
`endif

    // single-cycle boundary cases
    run_op("addi_ovf", 32'h2000_0001, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 3'b011, m_hi, m_lo, 2, 0);
    run_op("addiu_noovf", 32'h2400_0001, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 3'b001, m_hi, m_lo, 2, 0);
    run_op("sub_ovf", 32'h0000_0022, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 3'b010, m_hi, m_lo, 2, 0);
    run_op("slt", 32'h0000_002A, 32'hFFFF_FFFF, 32'h1, 32'h1, 3'b000, m_hi, m_lo, 2, 0);
    run_op("sltu", 32'h0000_002B, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b100, m_hi, m_lo, 2, 0);
    run_op("slti", 32'h2800_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h1, 3'b000, m_hi, m_lo, 2, 0);
    run_op("sll4", 32'h0000_0100, 32'h0, 32'h0000_000F, 32'h0000_00F0, 3'b000, m_hi, m_lo, 2, 0);
    run_op("sra4", 32'h0000_0103, 32'h0, 32'h8000_0000, 32'hF800_0000, 3'b001, m_hi, m_lo, 2, 0);
    run_op("srlv8", 32'h0000_0006, 32'h8, 32'h8000_0000, 32'h0080_0000, 3'b000, m_hi, m_lo, 2, 0);
    run_op("andi", 32'h3000_FF00, 32'h1234_5678, 32'h0, 32'h0000_5600, 3'b000, m_hi, m_lo, 2, 0);
    run_op("ori_zext", 32'h3400_8000, 32'h0, 32'h0, 32'h0000_8000, 3'b000, m_hi, m_lo, 2, 0);
    run_op("nor", 32'h0000_0027, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b001, m_hi, m_lo, 2, 0);
    run_op("xor_zero", 32'h0000_0026, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 3'b100, m_hi, m_lo, 2, 0);
    run_op("beq_eq", 32'h1000_0000, 32'h5, 32'h5, 32'h0, 3'b100, m_hi, m_lo, 2, 0);
    run_op("lw_addr", 32'h8C00_FFFC, 32'h0000_1000, 32'h0, 32'h0000_0FFC, 3'b000, m_hi, m_lo, 2, 0);
    run_op("unknown", 32'hFC00_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 3'b100, m_hi, m_lo, 2, 0);

    // reset on the 10th multiply iteration aborts with no hi/lo update
    send("multu_abort", 32'h0000_0019, 32'h3, 32'h5, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
    n = 0;
    lat = 0;
    while (n < 10 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) n++;
    end
    check("abort_reached_10", 32'(n), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_recover_in_ready", 32'(in_ready), 32'd1);
    m_hi = 32'h0; m_lo = 32'h0;
    run_op("addu_after_abort", 32'h0000_0021, 32'h1, 32'h2, 32'h3, 3'b000, m_hi, m_lo, 2, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_res_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
